// File: rtl/alu_issue_stage.sv
// Issue stage in front of a combinational 8-bit ALU: command FIFO in, head drives the ALU, result/flags out.
// Optional ALU_ISSUE_STATS_EN adds saturating fire/error counters (stat_ops, stat_err).
module alu_issue_stage #(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [2:0]       cmd_opcode,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [7:0]       alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_carry,
  output logic             rsp_illegal,
  output logic [LVL_W-1:0] fifo_level
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]      stat_ops,
  output logic [15:0]      stat_err
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd5;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  cmd_t             head;
  logic             empty, full, push, fire, head_illegal;

  assign empty        = (fifo_level == '0);
  assign full         = (fifo_level == LVL_W'(DEPTH));
  assign cmd_ready    = !full;
  assign push         = cmd_valid && !full;
  assign fire         = !empty && (!rsp_valid || rsp_ready);
  assign head         = mem[rd_ptr];
  assign head_illegal = (head.op[2:1] == 2'b11);

  // Empty or illegal head parks the ALU on a harmless AND of zeros.
  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = OP_AND;
    if (!empty && !head_illegal) begin
      alu_a      = head.a;
      alu_b      = head.b;
      alu_opcode = head.op;
    end
  end

  // NOTE: storage has no reset; validity is tracked by the pointers and level alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_opcode};
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fire) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, fire})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_illegal  <= 1'b0;
    end else if (fire) begin
      rsp_valid    <= 1'b1;
      rsp_result   <= head_illegal ? 8'h00 : alu_result;
      rsp_zero     <= !head_illegal && alu_zero;
      rsp_overflow <= !head_illegal && alu_overflow;
      rsp_carry    <= !head_illegal && alu_carry;
      rsp_illegal  <= head_illegal;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic fire_err;
  assign fire_err = head_illegal || (head.op == OP_DIV && head.b == 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops <= '0;
      stat_err <= '0;
    end else if (fire) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (fire_err && stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU model on the alu_* side.
module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [2:0] cmd_opcode;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_opcode;
  logic       alu_zero, alu_overflow, alu_carry;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_zero, rsp_overflow, rsp_carry, rsp_illegal;
  logic [2:0] fifo_level;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_ops, stat_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DEPTH(4), .LVL_W(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow), .rsp_carry(rsp_carry),
    .rsp_illegal(rsp_illegal), .fifo_level(fifo_level)
`ifdef ALU_ISSUE_STATS_EN
    , .stat_ops(stat_ops), .stat_err(stat_err)
`endif
  );

  // Reference ALU: SUB carry means borrow, MUL flags mean high byte nonzero.
  logic [8:0]  sum9;
  logic [15:0] prod;
  always_comb begin
    sum9         = '0;
    prod         = '0;
    alu_result   = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_opcode)
      3'd0: begin
        sum9         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = sum9[7:0];
        alu_carry    = sum9[8];
        alu_overflow = (alu_a[7] == alu_b[7]) && (sum9[7] != alu_a[7]);
      end
      3'd1: begin
        alu_result   = alu_a - alu_b;
        alu_carry    = alu_a < alu_b;
        alu_overflow = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: begin
        prod         = alu_a * alu_b;
        alu_result   = prod[7:0];
        alu_carry    = |prod[15:8];
        alu_overflow = |prod[15:8];
      end
      3'd5: begin
        if (alu_b == 8'h00) alu_overflow = 1'b1;
        else                alu_result   = alu_a / alu_b;
      end
      default: ;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    cmd_valid  = v;
    cmd_a      = a;
    cmd_b      = b;
    cmd_opcode = op;
  endtask

  int pushes, pops;
  bit done;

  initial begin
    rst = 1'b1;
    set_cmd(1'b0, 8'h00, 8'h00, 3'd0);
    rsp_ready = 1'b0;
    #2;
    check("rst_level", 16'(fifo_level), 16'd0);
    check("rst_cmd_ready", 16'(cmd_ready), 16'd1);
    check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    check("rst_rsp_bits", {4'h0, rsp_result, rsp_zero, rsp_overflow, rsp_carry, rsp_illegal}, 16'h0000);
    check("idle_alu_drive", {alu_a, alu_b[4:0], alu_opcode}, {8'h00, 5'h00, 3'd2});
    #10 rst = 1'b0;
    step();

    // Single ADD with overflow into bit 7.
    rsp_ready = 1'b1;
    set_cmd(1'b1, 8'h7F, 8'h01, 3'd0);
    step();
    cmd_valid = 1'b0;
    check("add_level_after_push", 16'(fifo_level), 16'd1);
    check("add_not_yet_valid", 16'(rsp_valid), 16'd0);
    check("add_alu_drive", {alu_a, alu_b}, 16'h7F01);
    step();
    check("add_rsp_valid", 16'(rsp_valid), 16'd1);
    check("add_rsp_result", 16'(rsp_result), 16'h80);
    check("add_flags_zoc", {rsp_zero, rsp_overflow, rsp_carry, rsp_illegal}, 16'b0100);
    step();
    check("add_rsp_drop", 16'(rsp_valid), 16'd0);

    // Stalled consumer: five commands, one in rsp and four buffered.
    rsp_ready = 1'b0;
    set_cmd(1'b1, 8'd1, 8'd1, 3'd0);    step();
    set_cmd(1'b1, 8'd2, 8'd2, 3'd0);    step();
    set_cmd(1'b1, 8'hF0, 8'h3C, 3'd2);  step();
    set_cmd(1'b1, 8'h0F, 8'hF0, 3'd3);  step();
    set_cmd(1'b1, 8'd3, 8'd5, 3'd4);    step();
    cmd_valid = 1'b0;
    check("full_level", 16'(fifo_level), 16'd4);
    check("full_cmd_ready", 16'(cmd_ready), 16'd0);
    check("full_rsp_head", {7'd0, rsp_valid, rsp_result}, {7'd0, 1'b1, 8'd2});
    step();
    check("full_rsp_held", {7'd0, rsp_valid, rsp_result}, {7'd0, 1'b1, 8'd2});
    rsp_ready = 1'b1;
    step();
    check("drain1", {7'd0, rsp_valid, rsp_result}, {7'd0, 1'b1, 8'd4});
    check("drain1_cmd_ready", 16'(cmd_ready), 16'd1);
    step();
    check("drain2", {7'd0, rsp_valid, rsp_result}, {7'd0, 1'b1, 8'h30});
    step();
    check("drain3", {7'd0, rsp_valid, rsp_result}, {7'd0, 1'b1, 8'hFF});
    step();
    check("drain4", {7'd0, rsp_valid, rsp_result}, {7'd0, 1'b1, 8'h0F});
    check("drain_level", 16'(fifo_level), 16'd0);
    step();
    check("drain_done", 16'(rsp_valid), 16'd0);

    // Illegal opcode followed by a legal ADD.
    set_cmd(1'b1, 8'd3, 8'd4, 3'd7);
    step();
    check("ill_alu_drive", {alu_a, alu_b[4:0], alu_opcode}, {8'h00, 5'h00, 3'd2});
    set_cmd(1'b1, 8'd3, 8'd4, 3'd0);
    step();
    cmd_valid = 1'b0;
    check("ill_rsp", {rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_carry, rsp_illegal},
          16'({1'b1, 8'h00, 4'b0001}));
    step();
    check("ill_next_rsp", {rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_carry, rsp_illegal},
          16'({1'b1, 8'd7, 4'b0000}));

    // DIV by zero passes ALU flags through and is not illegal.
    set_cmd(1'b1, 8'd9, 8'd0, 3'd5);
    step();
    cmd_valid = 1'b0;
    step();
    check("div0_rsp", {rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_carry, rsp_illegal},
          16'({1'b1, 8'h00, 4'b1100}));
`ifdef ALU_ISSUE_STATS_EN
    check("div0_stat_err", stat_err, 16'd2);
    check("div0_stat_ops", stat_ops, 16'd9);
`endif
    step();

    // Stream SUB 5-3 with a toggling consumer; responses counted against pushes.
    pushes = 0;
    pops   = 0;
    for (int i = 0; i < 12; i++) begin
      set_cmd(1'b1, 8'd5, 8'd3, 3'd1);
      rsp_ready = i[0];
      if (cmd_valid && cmd_ready) pushes++;
      if (rsp_valid && rsp_ready) begin
        pops++;
        check("sub_stream_rsp", {7'd0, rsp_carry, rsp_result}, {7'd0, 1'b0, 8'd2});
      end
      if (rsp_valid && !rsp_ready) begin
        step();
        check("sub_stall_hold", {7'd0, rsp_valid, rsp_result}, {7'd0, 1'b1, 8'd2});
      end else begin
        step();
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (rsp_valid) begin
        pops++;
        check("sub_drain_rsp", {7'd0, rsp_carry, rsp_result}, {7'd0, 1'b0, 8'd2});
      end
      if (!rsp_valid && fifo_level == 3'd0) done = 1'b1;
      else step();
    end
    check("sub_drain_finished", 16'(done), 16'd1);
    check("sub_no_loss", 16'(pops), 16'(pushes));

    // Asynchronous reset mid-operation with 3 queued and a held response.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'b1, 8'(i), 8'd1, 3'd0);
      step();
    end
    cmd_valid = 1'b0;
    check("pre_rst_state", {12'd0, rsp_valid, fifo_level}, 16'({1'b1, 3'd3}));
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", {12'd0, rsp_valid, fifo_level}, 16'd0);
    check("async_rst_ready", 16'(cmd_ready), 16'd1);
    check("async_rst_result", 16'(rsp_result), 16'd0);
    #3 rst = 1'b0;
    step();
    rsp_ready = 1'b1;
    set_cmd(1'b1, 8'd10, 8'd20, 3'd0);
    step();
    cmd_valid = 1'b0;
    step();
    check("post_rst_add", {7'd0, rsp_valid, rsp_result}, {7'd0, 1'b1, 8'd30});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
